// File: rtl/cic_decim_if.sv
// Control/handshake bundle between the CIC sequencing controller, the config
// side and the downstream sample consumer.
interface cic_decim_if #(
    parameter int unsigned OSR_WIDTH = 8
);
    logic                 enable;
    logic [OSR_WIDTH-1:0] osr;
    logic                 cfg_load;
    logic                 out_ready;
    logic                 integ_en;
    logic                 integ_clr;
    logic                 comb_en;
    logic                 out_load;
    logic                 out_valid;
    logic                 overrun;
    logic                 busy;

    // Config/consumer side
    modport master (
        output enable, osr, cfg_load, out_ready,
        input  integ_en, integ_clr, comb_en, out_load, out_valid, overrun, busy
    );

    // Controller side
    modport slave (
        input  enable, osr, cfg_load, out_ready,
        output integ_en, integ_clr, comb_en, out_load, out_valid, overrun, busy
    );
endinterface

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for one CIC decimator channel: integrator gating and
// clear, decimate-rate comb strobe, settling-output discard, output handshake.
module cic_decim_ctrl #(
    parameter int unsigned OSR_WIDTH = 8,
    parameter int unsigned N_STAGES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    cic_decim_if.slave bus
);
    localparam int unsigned WARM_W = (N_STAGES < 2) ? 1 : $clog2(N_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [OSR_WIDTH-1:0] osr_q, osr_d;
    logic [OSR_WIDTH-1:0] phase_q, phase_d;
    logic [WARM_W-1:0]    warm_q, warm_d;
    logic [OSR_WIDTH-1:0] osr_clamp_c;
    logic                 relatch_c;
    logic                 active_d_c;
    logic                 flush_d_c;

    logic integ_en_q,  integ_en_d;
    logic integ_clr_q, integ_clr_d;
    logic comb_en_q,   comb_en_d;
    logic out_load_q,  out_load_d;
    logic out_valid_q, out_valid_d;
    logic overrun_q,   overrun_d;
    logic busy_q,      busy_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; enable=0 beats cfg_load, which beats normal sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable) state_d = CLEAR;
            CLEAR:   state_d = WARMUP;
            WARMUP:  if (comb_en_q && (warm_q == WARM_W'(N_STAGES - 1))) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            if (!bus.enable) begin
                state_d = IDLE;
            end else if (bus.cfg_load) begin
                state_d = CLEAR;
            end
        end
    end

    // Next values of the registered outputs and the phase/warmup counters
    always_comb begin
        osr_d       = osr_q;
        phase_d     = phase_q;
        warm_d      = warm_q;
        integ_en_d  = 1'b0;
        integ_clr_d = 1'b0;
        comb_en_d   = 1'b0;
        out_load_d  = 1'b0;
        out_valid_d = 1'b0;
        overrun_d   = 1'b0;
        busy_d      = 1'b0;

        osr_clamp_c = (bus.osr < OSR_WIDTH'(2)) ? OSR_WIDTH'(2) : bus.osr;
        relatch_c   = bus.enable && ((state_q == IDLE) || bus.cfg_load);
        active_d_c  = (state_d == WARMUP) || (state_d == RUN);
        flush_d_c   = (state_d == IDLE) || (state_d == CLEAR);

        if (relatch_c) begin
            osr_d = osr_clamp_c;
        end

        if (flush_d_c) begin
            phase_d = '0;
            warm_d  = '0;
        end else if (state_q == CLEAR) begin
            phase_d = '0;
        end else begin
            phase_d = (phase_q == (osr_q - OSR_WIDTH'(1))) ? '0 : (phase_q + OSR_WIDTH'(1));
            if ((state_q == WARMUP) && comb_en_q) begin
                warm_d = warm_q + WARM_W'(1);
            end
        end

        integ_en_d  = active_d_c;
        integ_clr_d = (state_d == CLEAR);
        busy_d      = (state_d != IDLE);
        comb_en_d   = active_d_c && (phase_d == (osr_q - OSR_WIDTH'(1)));
        // The comb register needs one cycle, so the sample is loaded the cycle after comb_en
        out_load_d  = (state_q == RUN) && (state_d == RUN) && comb_en_q;

        if (!flush_d_c) begin
            out_valid_d = out_load_q || (out_valid_q && !bus.out_ready);
            overrun_d   = overrun_q || (out_load_q && out_valid_q && !bus.out_ready);
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osr_q       <= '0;
            phase_q     <= '0;
            warm_q      <= '0;
            integ_en_q  <= 1'b0;
            integ_clr_q <= 1'b0;
            comb_en_q   <= 1'b0;
            out_load_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            osr_q       <= osr_d;
            phase_q     <= phase_d;
            warm_q      <= warm_d;
            integ_en_q  <= integ_en_d;
            integ_clr_q <= integ_clr_d;
            comb_en_q   <= comb_en_d;
            out_load_q  <= out_load_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.integ_en  = integ_en_q;
    assign bus.integ_clr = integ_clr_q;
    assign bus.comb_en   = comb_en_q;
    assign bus.out_load  = out_load_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for the CIC decimation filter. It gates and clears the integrator chain, generates the decimate-rate comb enable from a programmable oversampling ratio, and discards the CIC settling outputs. It also drives a valid/ready handshake with overrun detection toward the downstream sample consumer. It sits between the register/config interface and the integrator/comb datapath, one instance per filter channel.

## Interface
- OSR_WIDTH, 8, width of the oversampling-ratio field.
- N_STAGES, 3, CIC order; number of decimated outputs discarded after every (re)start.
- clk  input  1  filter clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  level; 1 = run filter, 0 = stop.
- osr  input  OSR_WIDTH  decimation ratio R; values 0 and 1 are treated as 2.
- cfg_load  input  1  single-cycle pulse; relatch osr and restart.
- integ_en  output  1  clock enable to all integrator stages.
- integ_clr  output  1  synchronous clear to integrators and comb delay registers.
- comb_en  output  1  one-cycle pulse at the decimated rate; comb stages advance.
- out_load  output  1  one-cycle pulse; load the output sample register.
- out_valid  output  1  output sample available.
- out_ready  input  1  consumer accepts the sample when out_valid && out_ready at a clock edge.
- overrun  output  1  sticky; a sample was replaced before being accepted.
- busy  output  1  state != IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0. The state resets to IDLE, and phase, warm_cnt and osr_q reset to 0.
- States are IDLE, CLEAR, WARMUP and RUN.
  - IDLE: all outputs 0. With enable=1, latch osr_q = max(osr, 2) and go to CLEAR.
  - CLEAR: lasts exactly one cycle. integ_clr=1 and integ_en=0. Reset phase and warm_cnt to 0. Go to WARMUP.
  - WARMUP: integ_en=1. Each comb_en pulse increments warm_cnt. On the comb_en pulse where warm_cnt reaches N_STAGES, go to RUN. No out_load or out_valid is produced from warmup samples.
  - RUN: integ_en=1. Each comb_en pulse causes an out_load pulse on the next cycle.
- phase counter:
  - Counts 0..osr_q-1 while integ_en=1 and wraps to 0.
  - comb_en=1 for the cycle in which phase == osr_q-1, i.e. exactly one pulse per osr_q integ_en cycles.
- enable=0 in any non-IDLE state: go to IDLE next cycle. Clear out_valid, overrun, phase and warm_cnt. A pending out_load is suppressed.
- cfg_load=1 in any non-IDLE state:
  - Relatch osr_q from osr and go to CLEAR. Clear out_valid and overrun.
  - cfg_load has priority over comb_en and out_ready in the same cycle.
  - cfg_load in IDLE is ignored; osr is latched on the next start anyway.
- If enable=0 and cfg_load=1 in the same cycle, enable wins and the state goes to IDLE.
- Handshake:
  - out_valid sets on the cycle out_load=1.
  - out_valid clears after a clock edge with out_valid && out_ready, unless out_load is asserted in that same cycle, in which case it stays 1.
- Overrun: out_load while out_valid=1 and out_ready=0 sets overrun and the newest sample replaces the old one. overrun stays set until cfg_load, enable=0 or reset.
- osr changes without cfg_load have no effect until the next restart.

## Timing
- Start: enable rises at edge k.
  - State is CLEAR and integ_clr=1 in cycle k+1.
  - integ_en=1 from cycle k+2.
  - The first comb_en is in cycle k+1+osr_q.
- Latency from start to first out_load is (N_STAGES+1)·osr_q + 2 cycles. With the defaults and osr=4 that is 18 cycles after the enable edge.
- In RUN, out_load pulses have period exactly osr_q with no jitter. out_load trails its comb_en by 1 cycle, which matches the one-cycle comb register latency.
- out_ready may be held high permanently. In that case out_valid is a one-cycle pulse coincident-plus-one with out_load.
- Asynchronous reset mid-operation forces all outputs low immediately. On rst_n release the block waits in IDLE for enable.

## Test plan
- Basic run: reset, osr=4, enable=1, out_ready=1.
  - integ_clr is a single pulse.
  - comb_en has period 4.
  - The first 3 comb_en produce no out_load.
  - out_load every 4 cycles, starting 18 cycles after the enable edge.
- Clamp: osr=0 and then osr=1.
  - comb_en period is 2 in both cases.
  - osr=255 gives period 255, with phase wrapping 254→0.
- Backpressure: osr=4, out_ready=0 for 10 cycles after the first out_valid.
  - out_valid stays 1.
  - overrun sets at the second out_load.
  - out_ready=1 then clears out_valid 1 cycle later; overrun remains 1.
- Simultaneous events: out_ready=1 in the same cycle as out_load, with out_valid already 1.
  - out_valid stays 1 and overrun stays 0.
  - cfg_load coinciding with comb_en: comb_en still fires this cycle; next cycle is CLEAR with no out_load.
- Reconfigure: in RUN with osr=4, pulse cfg_load with osr=8.
  - integ_clr pulse; out_valid and overrun cleared.
  - 3 discarded outputs, then out_load period 8.
- Stop and reset: enable=0 in mid-WARMUP returns to IDLE with busy=0 next cycle. rst_n low mid-RUN zeroes all outputs asynchronously, before the next clock edge.
